// File: rtl/tick_meter_pkg.sv
// ----------------------------------------------------------------------------
// tick_meter_pkg
//   Shared types and constants for the tick period meter.
//   - ch_state_t : per-channel measurement state
//   - PERIOD_MAX : "no valid period" marker at the default 32-bit width
//   - is_measuring() : true in the states where the stall timeout is armed
// ----------------------------------------------------------------------------
package tick_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    STALLED = 2'd3
  } ch_state_t;

  // Period reported while no measurement is available, or after a stall.
  // Channels of other widths use an all-ones fill of their own width.
  localparam logic [31:0] PERIOD_MAX = 32'hFFFF_FFFF;

  // The stall timeout only runs while a tick interval is being timed.
  // IDLE has never seen a tick. STALLED has already timed out.
  function automatic logic is_measuring(input ch_state_t s);
    return (s == ARMED) || (s == RUNNING);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// ----------------------------------------------------------------------------
// tick_channel
//   One channel of the tick period meter. It measures the time between
//   successive tick pulses in whole microseconds. It also tracks the
//   direction and flags a stall when no tick arrives within TIMEOUT_US.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset
//   clear        synchronous soft clear back to the reset state
//   tick         single-cycle tick pulse
//   dir          direction, only looked at while tick is high
//   period       last measured period in us (all ones = none / stalled)
//   period_valid period holds a measured or stalled value
//   new_period   one-cycle pulse when a tick updates period
//   stalled      channel has timed out
//   dir_out      direction latched with the last tick
// ----------------------------------------------------------------------------
module tick_channel
  import tick_meter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CLK_PER_US = 50,
  parameter int TIMEOUT_US = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic             dir,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             new_period,
  output logic             stalled,
  output logic             dir_out
);

  localparam int PW = (CLK_PER_US > 2) ? $clog2(CLK_PER_US) : 1;

  localparam logic [PW-1:0]    PRESC_LAST  = PW'(CLK_PER_US - 1);
  localparam logic [PW-1:0]    PRESC_ONE   = PW'(1);
  localparam logic [WIDTH-1:0] ALL_ONES    = '1;
  localparam logic [WIDTH-1:0] TIMEOUT_VAL = WIDTH'(TIMEOUT_US);

  ch_state_t        state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] elapsed_q, elapsed_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             new_q, new_d;
  logic             stalled_q, stalled_d;
  logic             dir_out_q, dir_out_d;

  logic             rollover;
  logic [WIDTH-1:0] elapsed_next;

  // The prescaler restarts at 1 on a tick rather than at 0. The tick cycle
  // itself counts as the first clock of the new interval. This makes ticks
  // D clocks apart report exactly floor(D / CLK_PER_US).
  always_comb begin
    rollover     = (presc_q == PRESC_LAST);
    elapsed_next = (elapsed_q == ALL_ONES) ? elapsed_q : elapsed_q + 1'b1;
  end

  // Next-state logic. clear beats tick, and tick beats prescaler rollover
  // and timeout. A tick that lands on the timeout edge therefore still
  // produces a normal period.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    elapsed_d = elapsed_q;
    period_d  = period_q;
    valid_d   = valid_q;
    new_d     = 1'b0;
    stalled_d = stalled_q;
    dir_out_d = dir_out_q;

    if (clear) begin
      state_d   = IDLE;
      presc_d   = '0;
      elapsed_d = '0;
      period_d  = ALL_ONES;
      valid_d   = 1'b0;
      stalled_d = 1'b0;
      dir_out_d = 1'b0;
    end else if (tick) begin
      presc_d   = PRESC_ONE;
      elapsed_d = '0;
      unique case (state_q)
        IDLE: begin
          state_d   = ARMED;
          dir_out_d = dir;
        end
        ARMED: begin
          if (dir == dir_out_q) begin
            state_d  = RUNNING;
            period_d = elapsed_q;
            valid_d  = 1'b1;
            new_d    = 1'b1;
          end else begin
            dir_out_d = dir;
          end
        end
        RUNNING: begin
          if (dir == dir_out_q) begin
            period_d = elapsed_q;
            new_d    = 1'b1;
          end else begin
            // An interval that spans a reversal is not a speed sample.
            // Re-arm and wait for a clean same-direction interval.
            state_d   = ARMED;
            valid_d   = 1'b0;
            dir_out_d = dir;
          end
        end
        STALLED: begin
          state_d   = ARMED;
          stalled_d = 1'b0;
          valid_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      if (rollover) begin
        presc_d   = '0;
        elapsed_d = elapsed_next;
      end else begin
        presc_d = presc_q + 1'b1;
      end

      // The stall fires on the edge where elapsed reaches the timeout.
      if (is_measuring(state_q) && rollover && (elapsed_next == TIMEOUT_VAL)) begin
        state_d   = STALLED;
        stalled_d = 1'b1;
        period_d  = ALL_ONES;
        valid_d   = 1'b1;
      end
    end
  end

  // State and output registers. Reset discards everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      elapsed_q <= '0;
      period_q  <= ALL_ONES;
      valid_q   <= 1'b0;
      new_q     <= 1'b0;
      stalled_q <= 1'b0;
      dir_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      elapsed_q <= elapsed_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      new_q     <= new_d;
      stalled_q <= stalled_d;
      dir_out_q <= dir_out_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign new_period   = new_q;
  assign stalled      = stalled_q;
  assign dir_out      = dir_out_q;

endmodule

// File: rtl/tick_period_meter.sv
// ----------------------------------------------------------------------------
// tick_period_meter
//   Multi-channel tick period meter. It sits between the encoder/hall
//   decoders and the velocity estimator. Each channel runs independently
//   in its own tick_channel instance.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset
//   tick         per-channel tick pulse
//   dir          per-channel direction, sampled with tick
//   clear        synchronous soft clear of all channels
//   period       channel n in bits [n*WIDTH +: WIDTH], microseconds
//   period_valid per-channel period valid
//   new_period   per-channel one-cycle update strobe
//   stalled      per-channel timeout flag
//   dir_out      per-channel latched direction
// ----------------------------------------------------------------------------
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int WIDTH      = 32,
  parameter int CLK_PER_US = 50,
  parameter int TIMEOUT_US = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       tick,
  input  logic [NUM_CH-1:0]       dir,
  input  logic                    clear,
  output logic [NUM_CH*WIDTH-1:0] period,
  output logic [NUM_CH-1:0]       period_valid,
  output logic [NUM_CH-1:0]       new_period,
  output logic [NUM_CH-1:0]       stalled,
  output logic [NUM_CH-1:0]       dir_out
);

  // One fully independent channel per tick input. The outputs are packed
  // so that channel n owns slice n of each bus.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    tick_channel #(
      .WIDTH      (WIDTH),
      .CLK_PER_US (CLK_PER_US),
      .TIMEOUT_US (TIMEOUT_US)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .tick         (tick[ch]),
      .dir          (dir[ch]),
      .period       (period[ch*WIDTH +: WIDTH]),
      .period_valid (period_valid[ch]),
      .new_period   (new_period[ch]),
      .stalled      (stalled[ch]),
      .dir_out      (dir_out[ch])
    );
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// ----------------------------------------------------------------------------
// tb_tick_period_meter
//   Directed bench for tick_period_meter with CLK_PER_US=4, TIMEOUT_US=20
//   and two channels. Expected values are worked out by hand from the
//   tick spacing: a tick pair D clocks apart reports floor(D/4).
// ----------------------------------------------------------------------------
module tb_tick_period_meter;
  import tick_meter_pkg::*;

  localparam int NUM_CH     = 2;
  localparam int WIDTH      = 32;
  localparam int CLK_PER_US = 4;
  localparam int TIMEOUT_US = 20;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       dir;
  logic                    clear;
  logic [NUM_CH*WIDTH-1:0] period;
  logic [NUM_CH-1:0]       period_valid;
  logic [NUM_CH-1:0]       new_period;
  logic [NUM_CH-1:0]       stalled;
  logic [NUM_CH-1:0]       dir_out;

  int checks = 0;
  int errors = 0;

  tick_period_meter #(
    .NUM_CH     (NUM_CH),
    .WIDTH      (WIDTH),
    .CLK_PER_US (CLK_PER_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .dir          (dir),
    .clear        (clear),
    .period       (period),
    .period_valid (period_valid),
    .new_period   (new_period),
    .stalled      (stalled),
    .dir_out      (dir_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges and land 1 time unit after the last edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle tick on channel ch. Outputs are sampled right after the edge
  // that consumed the tick.
  task automatic apply_stimulus(input int ch, input logic d);
    tick[ch] = 1'b1;
    dir[ch]  = d;
    idle(1);
    tick[ch] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick  = '0;
    dir   = '0;
    clear = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);

    // Reset state
    check_output("rst_period0", period[31:0], PERIOD_MAX);
    check_output("rst_period1", period[63:32], PERIOD_MAX);
    check_output("rst_valid", 32'(period_valid), 32'h0);
    check_output("rst_new", 32'(new_period), 32'h0);
    check_output("rst_stalled", 32'(stalled), 32'h0);
    check_output("rst_dir_out", 32'(dir_out), 32'h0);

    // An IDLE channel never times out
    idle(100);
    check_output("idle_no_stall", 32'(stalled), 32'h0);
    check_output("idle_valid", 32'(period_valid), 32'h0);

    // ch0: ticks 40 clocks apart -> 10 us
    apply_stimulus(0, 1'b0);
    idle(39);
    apply_stimulus(0, 1'b0);
    check_output("p40_period0", period[31:0], 32'd10);
    check_output("p40_valid0", 32'(period_valid[0]), 32'h1);
    check_output("p40_new0", 32'(new_period[0]), 32'h1);
    check_output("p40_period1", period[63:32], PERIOD_MAX);
    check_output("p40_valid1", 32'(period_valid[1]), 32'h0);
    idle(1);
    check_output("p40_new0_drop", 32'(new_period[0]), 32'h0);

    // 43 clocks -> 10, then 39 clocks -> 9, then back-to-back -> 0
    idle(41);
    apply_stimulus(0, 1'b0);
    check_output("p43_period0", period[31:0], 32'd10);
    idle(38);
    apply_stimulus(0, 1'b0);
    check_output("p39_period0", period[31:0], 32'd9);
    check_output("p39_new0", 32'(new_period[0]), 32'h1);
    apply_stimulus(0, 1'b0);
    check_output("p1_period0", period[31:0], 32'd0);
    check_output("p1_new0", 32'(new_period[0]), 32'h1);

    // Reversal on ch0: invalidate, re-arm, then 12 clocks -> 3
    idle(9);
    apply_stimulus(0, 1'b1);
    check_output("rev_valid0", 32'(period_valid[0]), 32'h0);
    check_output("rev_dir_out0", 32'(dir_out[0]), 32'h1);
    check_output("rev_new0", 32'(new_period[0]), 32'h0);
    check_output("rev_period0_hold", period[31:0], 32'd0);
    idle(11);
    apply_stimulus(0, 1'b1);
    check_output("rev_p12_period0", period[31:0], 32'd3);
    check_output("rev_p12_valid0", 32'(period_valid[0]), 32'h1);
    check_output("rev_p12_new0", 32'(new_period[0]), 32'h1);

    // ch1 stall: 80 clocks after the arming tick
    apply_stimulus(1, 1'b0);
    idle(78);
    check_output("pre_stall1", 32'(stalled[1]), 32'h0);
    idle(1);
    check_output("stall1", 32'(stalled[1]), 32'h1);
    check_output("stall_period1", period[63:32], PERIOD_MAX);
    check_output("stall_valid1", 32'(period_valid[1]), 32'h1);
    check_output("stall_new1", 32'(new_period[1]), 32'h0);
    idle(5);
    apply_stimulus(1, 1'b0);
    check_output("unstall1", 32'(stalled[1]), 32'h0);
    check_output("unstall_valid1", 32'(period_valid[1]), 32'h0);
    idle(7);
    apply_stimulus(1, 1'b0);
    check_output("p8_period1", period[63:32], 32'd2);
    check_output("p8_valid1", 32'(period_valid[1]), 32'h1);

    // Tick on the edge elapsed would reach the timeout: tick wins
    idle(78);
    apply_stimulus(1, 1'b0);
    check_output("edge_period1", period[63:32], 32'd19);
    check_output("edge_stall1", 32'(stalled[1]), 32'h0);
    check_output("edge_new1", 32'(new_period[1]), 32'h1);

    // Clear together with ticks on both channels: clear wins
    clear = 1'b1;
    tick  = 2'b11;
    dir   = 2'b11;
    idle(1);
    clear = 1'b0;
    tick  = '0;
    dir   = '0;
    check_output("clr_period0", period[31:0], PERIOD_MAX);
    check_output("clr_period1", period[63:32], PERIOD_MAX);
    check_output("clr_valid", 32'(period_valid), 32'h0);
    check_output("clr_stalled", 32'(stalled), 32'h0);
    check_output("clr_dir_out", 32'(dir_out), 32'h0);
    check_output("clr_new", 32'(new_period), 32'h0);

    // A cleared channel re-arms from IDLE: 8 clocks -> 2
    apply_stimulus(0, 1'b0);
    idle(7);
    apply_stimulus(0, 1'b0);
    check_output("post_clr_period0", period[31:0], 32'd2);

    // Asynchronous reset mid-interval takes effect without a clock edge
    idle(5);
    #2;
    reset = 1'b1;
    #1;
    check_output("arst_period0", period[31:0], PERIOD_MAX);
    check_output("arst_valid", 32'(period_valid), 32'h0);
    check_output("arst_dir_out", 32'(dir_out), 32'h0);
    idle(2);
    reset = 1'b0;
    idle(1);
    check_output("arst_stalled", 32'(stalled), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
